// File: rtl/adder_serial_if.sv
// adder_serial_if: operand/result bundle between a requester and the serial adder
interface adder_serial_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (output start, sub, a, b, input busy, done, sum, carry, overflow);
    modport slave  (input start, sub, a, b, output busy, done, sum, carry, overflow);
endinterface

// File: rtl/adder_serial.sv
// adder_serial: multi-cycle add/subtract that sums CHUNK bits per clock
module adder_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic           clk,
    input logic           rst_n,
    adder_serial_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, acc, sum_r;
    logic [CW-1:0]    idx;
    logic             cin, busy_r, done_r, carry_r, ovf_r;
    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] acc_next;
    logic             msb_cin;

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = ovf_r;

    // add the current chunk and merge it into the partial result; msb_cin is only used on the last chunk
    always_comb begin
        a_c      = a_r[idx*CHUNK +: CHUNK];
        b_c      = b_r[idx*CHUNK +: CHUNK];
        part     = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cin};
        acc_next = acc | (WIDTH'(part[CHUNK-1:0]) << (idx*CHUNK));
        msb_cin  = part[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    end

    // control FSM with operand capture, chunk stepping and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            idx     <= '0;
            cin     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    acc <= acc_next;
                    cin <= part[CHUNK];
                    idx <= idx + 1'b1;
                    if (idx == CW'(N - 1)) begin
                        state   <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sum_r   <= acc_next;
                        carry_r <= part[CHUNK];
                        ovf_r   <= part[CHUNK] ^ msb_cin;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        a_r    <= bus.a;
                        b_r    <= bus.sub ? ~bus.b : bus.b;
                        cin    <= bus.sub;
                        acc    <= '0;
                        idx    <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: random and directed checks of adder_serial against a cycle-level arithmetic model
module tb_adder_serial;
    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    adder_serial_if #(.WIDTH(W)) bus ();

    adder_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference result as {overflow, carry, sum} from plain arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] full;
        logic       o;
        full = s ? ({1'b0, x} - {1'b0, y} + (W+1)'(1 << W)) : ({1'b0, x} + {1'b0, y});
        o = s ? (x[W-1] != y[W-1] && full[W-1] != x[W-1]) : (x[W-1] == y[W-1] && full[W-1] != x[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    int           left;
    logic [W+1:0] pend;
    logic [W+1:0] e_res;
    logic         e_done;
    wire          e_busy = (left > 0);

    // cycle-level model: an accepted start keeps the block busy for N cycles, then the result appears
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left   <= 0;
            pend   <= '0;
            e_res  <= '0;
            e_done <= 1'b0;
        end else begin
            e_done <= (left == 1);
            if (left == 1) e_res <= pend;
            if (left > 0) left <= left - 1;
            else if (bus.start) begin
                left <= N;
                pend <= ref_op(bus.a, bus.b, bus.sub);
            end
        end
    end

    always @(negedge clk) begin
        check("m_busy", bus.busy, e_busy);
        check("m_done", bus.done, e_done);
        check("m_sum", bus.sum, e_res[W-1:0]);
        check("m_carry", bus.carry, e_res[W]);
        check("m_ovf", bus.overflow, e_res[W+1]);
    end

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                      input logic [W-1:0] xs, input logic xc, input logic xo);
        int cyc, busy_n;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.sub   = isub;
        @(negedge clk);
        bus.start = 1'b0;
        cyc       = 1;
        busy_n    = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", cyc, 5);
        check("busy_cycles", busy_n, 4);
        check("op_sum", bus.sum, xs);
        check("op_carry", bus.carry, xc);
        check("op_ovf", bus.overflow, xo);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_done"}, bus.done, 0);
        check({name, "_sum"}, bus.sum, 0);
        check({name, "_carry"}, bus.carry, 0);
        check({name, "_ovf"}, bus.overflow, 0);
    endtask

    initial begin
        int cyc, dn;
        logic [W-1:0] dsum;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        check("model_add", ref_op(8'h5A, 8'h3C, 1'b0), {1'b1, 1'b0, 8'h96});
        check("model_sub", ref_op(8'h80, 8'h01, 1'b1), {1'b1, 1'b1, 8'h7F});
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
        end
        bus.start = 1'b1; bus.a = 8'h02; bus.b = 8'h03; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        dn = 0;
        dsum = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin dn++; dsum = bus.sum; end
            @(negedge clk);
        end
        check("ignore_done_count", dn, 1);
        check("ignore_sum", dsum, 8'h05);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.sub = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (!bus.done && cyc < 20) begin @(negedge clk); cyc++; end
        check("b2b_first_cycle", cyc, 5);
        check("b2b_first_sum", bus.sum, 8'h96);
        bus.a = 8'h01; bus.b = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_hold_sum", bus.sum, 8'h96);
        check("b2b_busy", bus.busy, 1);
        cyc = 1;
        while (!bus.done && cyc < 20) begin @(negedge clk); cyc++; end
        check("b2b_spacing", cyc, 5);
        check("b2b_second_sum", bus.sum, 8'h03);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h44; bus.b = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("abort_no_done", dn, 0);
        check("abort_sum", bus.sum, 0);
        op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.sub   = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
